fx2_tag_writer: RTL and testbench
=================================

Name: fx2_tag_writer

Overview:
- Write-side stage of the FX2 slave-FIFO interface, directly downstream of the photon time-tag producer.
- Accepts fixed-width time-tag words over a valid/ready handshake and serialises them LSB-byte-first onto the 8-bit FX2 data bus into FIFO4 (IN endpoint).
- Issues PKTEND after an idle timeout so partial packets reach the host without waiting for 512 bytes.
- All FX2 signals on this block are positive logic; the top level performs the inversions.

Parameters:
- TAG_BYTES, 4: bytes per tag word; tag width is 8*TAG_BYTES.
- PKT_BYTES, 512: FX2 endpoint packet size. Must be a multiple of TAG_BYTES.
- FLUSH_TIMEOUT, 4096: idle FIFO_CLK cycles with a partial packet pending before PKTEND is issued.
- FIFOADR, 2'b01: FIFOADR value driven while writing (selects FIFO4).

Ports:
- FIFO_CLK, in, 1: sole clock (FX2 IFCLK). One clock; reset is asynchronous and active-high.
- FIFO_RST, in, 1: asynchronous, active-high reset.
- tag_data, in, 8*TAG_BYTES: time-tag word.
- tag_valid, in, 1: tag_data valid.
- tag_ready, out, 1: word accepted when tag_valid && tag_ready.
- FIFO_ready_to_accept_data, in, 1: FIFO4 not full.
- FIFO_WR, out, 1: write strobe; one byte per cycle when high.
- FIFO_DATAOUT, out, 8: byte to FX2.
- FIFO_DATAOUT_OE, out, 1: bus drive enable.
- FIFO_PKTEND, out, 1: commit partial packet; 1-cycle pulse.
- FIFO_FIFOADR, out, 2: endpoint select; constant FIFOADR.

Behaviour:
- Reset values: all outputs 0 except FIFO_FIFOADR = FIFOADR. State = IDLE; byte index, packet count and timeout counter = 0.
- FSM IDLE: tag_ready = 1. On accept, latch the word into shift register sr, set byte index = 0 and go to SEND.
- FSM SEND:
  - FIFO_DATAOUT_OE = 1 and FIFO_DATAOUT = sr[7:0].
  - FIFO_WR = FIFO_ready_to_accept_data, combinational from the registered state.
  - On each write: shift sr right 8, increment byte index, increment packet count modulo PKT_BYTES.
  - While not ready: hold all registers; no byte is lost or duplicated.
- Last byte (index TAG_BYTES-1) written:
  - tag_ready = 1 in that same cycle.
  - If a new word is accepted, reload sr and stay in SEND (no bubble, 1 byte/cycle sustained).
  - Otherwise go to IDLE.
- Accept-to-first-WR latency: 1 cycle.
- Timeout counter:
  - Clears on any accept, and whenever packet count = 0.
  - Increments in IDLE while packet count != 0; saturates at FLUSH_TIMEOUT.
- Reaching FLUSH_TIMEOUT in IDLE moves the FSM to FLUSH.
- FSM FLUSH:
  - tag_ready = 0. FIFO_PKTEND = 1 for one cycle, only when FIFO_ready_to_accept_data = 1; otherwise wait.
  - On the pulse: clear packet count and timeout, return to IDLE.
- Packet count wraps PKT_BYTES-1 -> 0 on a write. A full packet auto-commits and never generates PKTEND.
- Simultaneous tag_valid and timeout expiry in the same IDLE cycle: the tag wins, the timeout clears and no PKTEND is issued.
- PKTEND never coincides with FIFO_WR and is never issued when packet count = 0.
- FIFO_RST asserted mid-word: the partial word is discarded and all outputs return to reset values asynchronously. The host may see a truncated tag; the stream resynchronises at the next packet.

Optional Feature:
- Macro FX2W_SYNC_WORD_EN.
- Defined:
  - When a tag is accepted and packet count = 0, TAG_BYTES bytes of the constant SYNC_WORD (0xA5A5...A5) are written first, then the tag.
  - New FSM state SYNC precedes SEND; tag_ready = 0 during SYNC.
  - PKT_BYTES must still be a multiple of TAG_BYTES. The first tag of every packet therefore costs 2*TAG_BYTES bytes.
- Undefined: no SYNC state; raw tags only.

Decomposition:
- Package fx2_pkg:
  - FX2 FIFOADR encodings (FIFO2=00, FIFO4=01, FIFO6=10, FIFO8=11).
  - SYNC_WORD_BYTE = 8'hA5.
  - State enum {IDLE, SYNC, SEND, FLUSH}.
  - Default PKT_BYTES.
- Sub-module fx2_flush_timer: saturating timeout counter with clear/enable and an expired output. Counter width is $clog2(FLUSH_TIMEOUT+1). Everything else stays in one module.

Test Plan:
- Single tag 0x44332211, ready=1:
  - WR high for 4 consecutive cycles, bytes 11,22,33,44, first byte 1 cycle after accept.
  - After FLUSH_TIMEOUT idle cycles, one PKTEND pulse.
- Back-to-back 128 tags (512 bytes), ready=1:
  - 512 contiguous WR cycles with no gaps.
  - Packet count wraps to 0 and no PKTEND ever follows.
- Tag 0xDDCCBBAA with ready dropped after byte BB for 5 cycles:
  - WR low for those cycles with DATAOUT held at CC.
  - Sequence AA,BB,CC,DD with no duplicates.
- Partial packet (3 tags), then tag_valid in the exact cycle the timeout would expire:
  - No PKTEND; new tag written.
  - PKTEND follows a subsequent full FLUSH_TIMEOUT idle period.
- FIFO_RST asserted mid-word after 2 bytes:
  - WR/OE/PKTEND drop to 0 immediately, tag_ready = 0 during reset.
  - After release, the next tag starts at byte 0 with packet count 0.
- With FX2W_SYNC_WORD_EN defined, first tag 0x04030201:
  - Bytes A5,A5,A5,A5,01,02,03,04.
  - Second tag emitted without a sync word.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: endpoint address encodings, sync byte,
// tag-writer state encoding and the default endpoint packet size.
package fx2_pkg;

    localparam logic [1:0] FIFOADR_FIFO2 = 2'b00;
    localparam logic [1:0] FIFOADR_FIFO4 = 2'b01;
    localparam logic [1:0] FIFOADR_FIFO6 = 2'b10;
    localparam logic [1:0] FIFOADR_FIFO8 = 2'b11;

    localparam logic [7:0] SYNC_WORD_BYTE = 8'hA5;

    localparam int PKT_BYTES_DEFAULT = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } fx2_state_t;

endpackage

// File: rtl/fx2_flush_timer.sv
// Saturating idle counter: counts enabled cycles up to FLUSH_TIMEOUT and
// flags expiry until cleared.
module fx2_flush_timer #(
    parameter int FLUSH_TIMEOUT = 4096
) (
    input  logic FIFO_CLK,
    input  logic FIFO_RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FLUSH_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge FIFO_CLK or posedge FIFO_RST) begin
        if (FIFO_RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/fx2_tag_writer.sv
// Serialises time-tag words LSB-byte-first into FX2 FIFO4 with idle PKTEND flush.
// Optional FX2W_SYNC_WORD_EN: prefix the first tag of each packet with an A5 sync word.
module fx2_tag_writer
    import fx2_pkg::*;
#(
    parameter int         TAG_BYTES     = 4,
    parameter int         PKT_BYTES     = PKT_BYTES_DEFAULT,
    parameter int         FLUSH_TIMEOUT = 4096,
    parameter logic [1:0] FIFOADR       = FIFOADR_FIFO4
) (
    input  logic                   FIFO_CLK,
    input  logic                   FIFO_RST,
    input  logic [8*TAG_BYTES-1:0] tag_data,
    input  logic                   tag_valid,
    output logic                   tag_ready,
    input  logic                   FIFO_ready_to_accept_data,
    output logic                   FIFO_WR,
    output logic [7:0]             FIFO_DATAOUT,
    output logic                   FIFO_DATAOUT_OE,
    output logic                   FIFO_PKTEND,
    output logic [1:0]             FIFO_FIFOADR
);

    localparam int TAG_W = 8 * TAG_BYTES;
    localparam int IDX_W = (TAG_BYTES > 1) ? $clog2(TAG_BYTES) : 1;
    localparam int PC_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAG_BYTES - 1);
    localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(PKT_BYTES - 1);

`ifdef FX2W_SYNC_WORD_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    fx2_state_t       state, nxt;
    logic [TAG_W-1:0] sr;
    logic [IDX_W-1:0] byte_idx;
    logic [PC_W-1:0]  pkt_cnt;

    logic       ready_c;
    logic       wr;
    logic       oe;
    logic [7:0] dout;
    logic       pktend;
    logic       accept;
    logic       expired;

    always_comb begin
        nxt     = state;
        ready_c = 1'b0;
        wr      = 1'b0;
        oe      = 1'b0;
        dout    = 8'h00;
        pktend  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                // A waiting tag beats a simultaneous timeout expiry.
                if (tag_valid) begin
                    nxt = (SYNC_EN && pkt_cnt == '0) ? SYNC : SEND;
                end else if (expired) begin
                    nxt = FLUSH;
                end
            end
`ifdef FX2W_SYNC_WORD_EN
            SYNC: begin
                oe   = 1'b1;
                dout = SYNC_WORD_BYTE;
                wr   = FIFO_ready_to_accept_data;
                if (wr && byte_idx == LAST_IDX) begin
                    nxt = SEND;
                end
            end
`endif
            SEND: begin
                oe   = 1'b1;
                dout = sr[7:0];
                wr   = FIFO_ready_to_accept_data;
                if (wr && byte_idx == LAST_IDX) begin
                    ready_c = 1'b1;
                    if (tag_valid) begin
                        // This write closes the packet when pkt_cnt is at its last slot.
                        nxt = (SYNC_EN && pkt_cnt == LAST_PC) ? SYNC : SEND;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (FIFO_ready_to_accept_data) begin
                    pktend = 1'b1;
                    nxt    = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign accept = ready_c && tag_valid;

    always_ff @(posedge FIFO_CLK or posedge FIFO_RST) begin
        if (FIFO_RST) begin
            state    <= IDLE;
            byte_idx <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                byte_idx <= '0;
            end else if (wr) begin
                byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
            end
            if (wr) begin
                pkt_cnt <= (pkt_cnt == LAST_PC) ? '0 : pkt_cnt + 1'b1;
            end else if (pktend) begin
                pkt_cnt <= '0;
            end
        end
    end

    // Data shift register needs no reset: it is only observed while OE is high.
    always_ff @(posedge FIFO_CLK) begin
        if (accept) begin
            sr <= tag_data;
        end else if (wr && state == SEND) begin
            sr <= sr >> 8;
        end
    end

    fx2_flush_timer #(
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) u_flush_timer (
        .FIFO_CLK(FIFO_CLK),
        .FIFO_RST(FIFO_RST),
        .clr     (accept || pkt_cnt == '0 || pktend),
        .en      (state == IDLE && pkt_cnt != '0),
        .expired (expired)
    );

    assign tag_ready       = ready_c && !FIFO_RST;
    assign FIFO_WR         = wr;
    assign FIFO_DATAOUT    = dout;
    assign FIFO_DATAOUT_OE = oe;
    assign FIFO_PKTEND     = pktend;
    assign FIFO_FIFOADR    = FIFOADR;

endmodule

// File: tb/tb_fx2_tag_writer.sv
// Directed self-checking bench for fx2_tag_writer (short FLUSH_TIMEOUT).
module tb_fx2_tag_writer;

    localparam int FT = 16;

    logic        FIFO_CLK = 1'b0;
    logic        FIFO_RST = 1'b0;
    logic [31:0] tag_data = '0;
    logic        tag_valid = 1'b0;
    logic        tag_ready;
    logic        FIFO_ready_to_accept_data = 1'b0;
    logic        FIFO_WR;
    logic [7:0]  FIFO_DATAOUT;
    logic        FIFO_DATAOUT_OE;
    logic        FIFO_PKTEND;
    logic [1:0]  FIFO_FIFOADR;

    int checks = 0;
    int errors = 0;

    fx2_tag_writer #(
        .TAG_BYTES    (4),
        .PKT_BYTES    (512),
        .FLUSH_TIMEOUT(FT),
        .FIFOADR      (2'b01)
    ) dut (
        .FIFO_CLK                 (FIFO_CLK),
        .FIFO_RST                 (FIFO_RST),
        .tag_data                 (tag_data),
        .tag_valid                (tag_valid),
        .tag_ready                (tag_ready),
        .FIFO_ready_to_accept_data(FIFO_ready_to_accept_data),
        .FIFO_WR                  (FIFO_WR),
        .FIFO_DATAOUT             (FIFO_DATAOUT),
        .FIFO_DATAOUT_OE          (FIFO_DATAOUT_OE),
        .FIFO_PKTEND              (FIFO_PKTEND),
        .FIFO_FIFOADR             (FIFO_FIFOADR)
    );

    always #5 FIFO_CLK = ~FIFO_CLK;

    task automatic step();
        @(posedge FIFO_CLK);
        #1;
    endtask

    function automatic logic [31:0] tagval(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    task automatic test_reset();
        FIFO_RST = 1'b1;
        tag_valid = 1'b0;
        FIFO_ready_to_accept_data = 1'b1;
        step();
        step();
        #1;
        checks++; if (tag_ready !== 1'b0) begin errors++; $display("FAIL rst_tag_ready got %b exp 0", tag_ready); end
        checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL rst_wr got %b exp 0", FIFO_WR); end
        checks++; if (FIFO_DATAOUT_OE !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", FIFO_DATAOUT_OE); end
        checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL rst_pktend got %b exp 0", FIFO_PKTEND); end
        checks++; if (FIFO_DATAOUT !== 8'h00) begin errors++; $display("FAIL rst_dataout got %h exp 00", FIFO_DATAOUT); end
        checks++; if (FIFO_FIFOADR !== 2'b01) begin errors++; $display("FAIL rst_fifoadr got %b exp 01", FIFO_FIFOADR); end
        FIFO_RST = 1'b0;
        step();
        #1;
        checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL idle_tag_ready got %b exp 1", tag_ready); end
        step();
    endtask

`ifndef FX2W_SYNC_WORD_EN
    task automatic test_single();
        tag_data = 32'h44332211;
        tag_valid = 1'b1;
        #1;
        checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL single_accept_ready got %b exp 1", tag_ready); end
        checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL single_accept_wr got %b exp 0", FIFO_WR); end
        step();
        tag_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (FIFO_WR !== 1'b1) begin errors++; $display("FAIL single_wr[%0d] got %b exp 1", i, FIFO_WR); end
            checks++; if (FIFO_DATAOUT !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL single_byte[%0d] got %h exp %h", i, FIFO_DATAOUT, 8'(8'h11 * (i + 1))); end
            step();
        end
        for (int j = 0; j < FT + 4; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== (j == FT + 1)) begin errors++; $display("FAIL single_pktend[%0d] got %b exp %b", j, FIFO_PKTEND, (j == FT + 1)); end
            checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL single_idle_wr[%0d] got %b exp 0", j, FIFO_WR); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        tag_data = tagval(0);
        tag_valid = 1'b1;
        step();
        for (int c = 0; c < 512; c++) begin
            if (c % 4 == 0) begin
                tag_data = tagval(c / 4 + 1);
                tag_valid = (c / 4 + 1 < 128);
            end
            #1;
            checks++; if (FIFO_WR !== 1'b1) begin errors++; $display("FAIL b2b_wr[%0d] got %b exp 1", c, FIFO_WR); end
            checks++; if (FIFO_DATAOUT !== 8'(c)) begin errors++; $display("FAIL b2b_byte[%0d] got %h exp %h", c, FIFO_DATAOUT, 8'(c)); end
            if (c % 4 == 3) begin
                checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", c, tag_ready); end
            end
            step();
        end
        tag_valid = 1'b0;
        for (int j = 0; j < FT + 6; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL b2b_no_pktend[%0d] got %b exp 0", j, FIFO_PKTEND); end
            checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL b2b_idle_wr[%0d] got %b exp 0", j, FIFO_WR); end
            step();
        end
    endtask

    task automatic test_stall();
        logic       rdy [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp [9] = '{8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hDD};
        tag_data = 32'hDDCCBBAA;
        tag_valid = 1'b1;
        step();
        tag_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            FIFO_ready_to_accept_data = rdy[i];
            #1;
            checks++; if (FIFO_WR !== rdy[i]) begin errors++; $display("FAIL stall_wr[%0d] got %b exp %b", i, FIFO_WR, rdy[i]); end
            checks++; if (FIFO_DATAOUT !== exp[i]) begin errors++; $display("FAIL stall_byte[%0d] got %h exp %h", i, FIFO_DATAOUT, exp[i]); end
            checks++; if (FIFO_DATAOUT_OE !== 1'b1) begin errors++; $display("FAIL stall_oe[%0d] got %b exp 1", i, FIFO_DATAOUT_OE); end
            step();
        end
        for (int j = 0; j < FT + 4; j++) begin
            FIFO_ready_to_accept_data = (j <= FT);
            #1;
            checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL stall_flush_wait[%0d] got %b exp 0", j, FIFO_PKTEND); end
            if (j > FT) begin
                checks++; if (tag_ready !== 1'b0) begin errors++; $display("FAIL flush_ready[%0d] got %b exp 0", j, tag_ready); end
            end
            step();
        end
        FIFO_ready_to_accept_data = 1'b1;
        #1;
        checks++; if (FIFO_PKTEND !== 1'b1) begin errors++; $display("FAIL stall_pktend got %b exp 1", FIFO_PKTEND); end
        checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL stall_pktend_wr got %b exp 0", FIFO_WR); end
        step();
        #1;
        checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL stall_pktend_once got %b exp 0", FIFO_PKTEND); end
        step();
    endtask

    task automatic test_timeout_race();
        tag_data = tagval(0);
        tag_valid = 1'b1;
        step();
        for (int c = 0; c < 12; c++) begin
            if (c % 4 == 0) begin
                tag_data = tagval(c / 4 + 1);
                tag_valid = (c / 4 + 1 < 3);
            end
            #1;
            checks++; if (FIFO_DATAOUT !== 8'(c) || FIFO_WR !== 1'b1) begin errors++; $display("FAIL race_byte[%0d] got %h/%b exp %h/1", c, FIFO_DATAOUT, FIFO_WR, 8'(c)); end
            step();
        end
        tag_valid = 1'b0;
        for (int j = 0; j < FT; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL race_idle_pktend[%0d] got %b exp 0", j, FIFO_PKTEND); end
            step();
        end
        tag_data = 32'h87654321;
        tag_valid = 1'b1;
        #1;
        checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL race_ready got %b exp 1", tag_ready); end
        checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL race_pktend got %b exp 0", FIFO_PKTEND); end
        step();
        tag_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (FIFO_DATAOUT !== 8'(8'h21 + 8'h22 * i) || FIFO_WR !== 1'b1) begin errors++; $display("FAIL race_tag_byte[%0d] got %h/%b exp %h/1", i, FIFO_DATAOUT, FIFO_WR, 8'(8'h21 + 8'h22 * i)); end
            checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL race_tag_pktend[%0d] got %b exp 0", i, FIFO_PKTEND); end
            step();
        end
        for (int j = 0; j < FT + 3; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== (j == FT + 1)) begin errors++; $display("FAIL race_late_pktend[%0d] got %b exp %b", j, FIFO_PKTEND, (j == FT + 1)); end
            step();
        end
    endtask

    task automatic test_reset_midword();
        tag_data = 32'h0C0B0A09;
        tag_valid = 1'b1;
        step();
        tag_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (FIFO_DATAOUT !== 8'(9 + i) || FIFO_WR !== 1'b1) begin errors++; $display("FAIL mid_byte[%0d] got %h/%b exp %h/1", i, FIFO_DATAOUT, FIFO_WR, 8'(9 + i)); end
            step();
        end
        FIFO_RST = 1'b1;
        #1;
        checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got %b exp 0", FIFO_WR); end
        checks++; if (FIFO_DATAOUT_OE !== 1'b0) begin errors++; $display("FAIL mid_rst_oe got %b exp 0", FIFO_DATAOUT_OE); end
        checks++; if (FIFO_PKTEND !== 1'b0) begin errors++; $display("FAIL mid_rst_pktend got %b exp 0", FIFO_PKTEND); end
        checks++; if (tag_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", tag_ready); end
        step();
        FIFO_RST = 1'b0;
        for (int j = 0; j < FT + 5; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== 1'b0 || FIFO_WR !== 1'b0) begin errors++; $display("FAIL mid_after_rst[%0d] got pktend %b wr %b exp 0 0", j, FIFO_PKTEND, FIFO_WR); end
            step();
        end
        tag_data = 32'h14131211;
        tag_valid = 1'b1;
        step();
        tag_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (FIFO_DATAOUT !== 8'(8'h11 + i) || FIFO_WR !== 1'b1) begin errors++; $display("FAIL mid_next_byte[%0d] got %h/%b exp %h/1", i, FIFO_DATAOUT, FIFO_WR, 8'(8'h11 + i)); end
            step();
        end
        for (int j = 0; j < FT + 3; j++) begin
            #1;
            checks++; if (FIFO_PKTEND !== (j == FT + 1)) begin errors++; $display("FAIL mid_pktend[%0d] got %b exp %b", j, FIFO_PKTEND, (j == FT + 1)); end
            step();
        end
    endtask
`else
    task automatic test_sync();
        tag_data = 32'h04030201;
        tag_valid = 1'b1;
        #1;
        checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL sync_accept_ready got %b exp 1", tag_ready); end
        step();
        tag_data = 32'h08070605;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) tag_valid = 1'b0;
            #1;
            checks++; if (FIFO_WR !== 1'b1) begin errors++; $display("FAIL sync_wr[%0d] got %b exp 1", i, FIFO_WR); end
            checks++; if (FIFO_DATAOUT !== ((i < 4) ? 8'hA5 : 8'(i - 3))) begin errors++; $display("FAIL sync_byte[%0d] got %h exp %h", i, FIFO_DATAOUT, ((i < 4) ? 8'hA5 : 8'(i - 3))); end
            if (i < 8) begin
                checks++; if (tag_ready !== (i == 7)) begin errors++; $display("FAIL sync_ready[%0d] got %b exp %b", i, tag_ready, (i == 7)); end
            end
            step();
        end
        #1;
        checks++; if (FIFO_WR !== 1'b0) begin errors++; $display("FAIL sync_end_wr got %b exp 0", FIFO_WR); end
        step();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef FX2W_SYNC_WORD_EN
        test_sync();
`else
        test_single();
        test_back_to_back();
        test_stall();
        test_timeout_race();
        test_reset_midword();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
